// File: rtl/fifo_sync_ctrl.sv
// fifo_sync_ctrl: FWFT FIFO controller for a true-dual-port RAM, with a 2-entry
// output skid buffer that hides the RAM's registered read latency.
module fifo_sync_ctrl #(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 4,
  parameter int AFULL_LVL = 2**ASIZE-2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [DSIZE-1:0] din,
  output logic             full,
  output logic             afull,
  input  logic             rd_en,
  output logic [DSIZE-1:0] dout,
  output logic             empty,
  output logic [ASIZE:0]   count,
  output logic             ovf,
  output logic             unf,
  output logic             ram_ena,
  output logic             ram_wea,
  output logic [ASIZE-1:0] ram_addra,
  output logic [DSIZE-1:0] ram_dia,
  output logic             ram_enb,
  output logic [ASIZE-1:0] ram_addrb,
  input  logic [DSIZE-1:0] ram_dob
);
  localparam logic [ASIZE:0] DEPTH_L = (ASIZE+1)'(2**ASIZE);
  localparam logic [ASIZE:0] AFULL_L = (ASIZE+1)'(AFULL_LVL);
  logic [ASIZE-1:0] wptr, rptr;
  logic [ASIZE:0]   mem_lvl, mem_lvl_n, count_n;
  logic             inflight, push, pop, issue;
  logic [1:0]       obuf_lvl, obuf_lvl_n, lvl_pop;
  logic [DSIZE-1:0] obuf0, obuf1, obuf0_n, obuf1_n;
  // mem_lvl only counts words committed on earlier edges, so a read never
  // targets the address being written in the same cycle.
  always_comb begin
    push       = wr_en & ~full & ~rst;
    pop        = rd_en & ~empty;
    issue      = ~rst & (mem_lvl != '0) &
                 (({1'b0, obuf_lvl} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
    lvl_pop    = obuf_lvl - {1'b0, pop};
    obuf0_n    = (inflight && lvl_pop == 2'd0) ? ram_dob : (pop ? obuf1 : obuf0);
    obuf1_n    = (inflight && lvl_pop == 2'd1) ? ram_dob : obuf1;
    obuf_lvl_n = lvl_pop + {1'b0, inflight};
    mem_lvl_n  = mem_lvl + (ASIZE+1)'(push) - (ASIZE+1)'(issue);
    count_n    = count + (ASIZE+1)'(push) - (ASIZE+1)'(pop);
  end
  assign ram_ena   = push;
  assign ram_wea   = push;
  assign ram_addra = wptr;
  assign ram_dia   = din;
  assign ram_enb   = issue;
  assign ram_addrb = rptr;
  assign dout      = obuf0;
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      mem_lvl  <= '0;
      inflight <= 1'b0;
      obuf_lvl <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      afull    <= 1'b0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end else begin
      wptr     <= wptr + ASIZE'(push);
      rptr     <= rptr + ASIZE'(issue);
      mem_lvl  <= mem_lvl_n;
      inflight <= issue;
      obuf_lvl <= obuf_lvl_n;
      count    <= count_n;
      empty    <= obuf_lvl_n == 2'd0;
      full     <= count_n == DEPTH_L;
      afull    <= count_n >= AFULL_L;
      ovf      <= wr_en & full;
      unf      <= rd_en & empty;
    end
  end
  // Skid data carries no reset; empty gates its validity.
  always_ff @(posedge clk) begin
    obuf0 <= obuf0_n;
    obuf1 <= obuf1_n;
  end
endmodule

// File: doc/fifo_sync_ctrl.md
Name: fifo_sync_ctrl

Overview:
- Single-clock first-word-fall-through (FWFT) FIFO controller that drives the FIFO's true-dual-port block RAM.
- Port A of the RAM is write-only from this block; port B is read-only.
- Owns the pointers, the occupancy and the status flags, and holds a 2-entry output skid buffer that hides the RAM's 1-cycle read latency.
- Sits directly upstream of the RAM on both address/enable paths and downstream of it on the read-data path.

Parameters:
- DSIZE, 8, data width; must equal the RAM's DSIZE.
- ASIZE, 4, RAM address width; depth = 2**ASIZE; legal range ASIZE >= 2.
- AFULL_LVL, 2**ASIZE-2, occupancy at or above which afull asserts.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous reset, active-high.
- wr_en  in  1  push request.
- din  in  DSIZE  push data.
- full  out  1  registered; occupancy == 2**ASIZE.
- afull  out  1  registered; occupancy >= AFULL_LVL.
- rd_en  in  1  pop request; consumes dout.
- dout  out  DSIZE  head word; valid while empty==0.
- empty  out  1  registered; skid buffer holds no word.
- count  out  ASIZE+1  total occupancy: RAM + in-flight + skid.
- ovf  out  1  1-cycle pulse; wr_en while full.
- unf  out  1  1-cycle pulse; rd_en while empty.
- ram_ena, ram_wea  out  1  port A enable and write enable.
- ram_addra  out  ASIZE  port A address (write pointer).
- ram_dia  out  DSIZE  port A data; equals din.
- ram_enb  out  1  port B enable (read issue); the block never asserts the RAM's port B write enable.
- ram_addrb  out  ASIZE  port B address (read pointer).
- ram_dob  in  DSIZE  port B registered read data.

Behaviour:
- Reset:
  - wptr = rptr = 0; mem_lvl = 0; inflight = 0; obuf_lvl = 0.
  - count = 0; empty = 1; full = 0; afull = 0; ovf = 0; unf = 0.
  - During rst, ram_ena and ram_enb are forced to 0.
  - Reset mid-operation discards all contents. Any read already in flight is dropped and its ram_dob is never captured.
- Accepted push:
  - push = wr_en & ~full.
  - ram_ena = ram_wea = push; ram_addra = wptr; wptr += 1 and wraps naturally modulo 2**ASIZE.
- Read issue:
  - issue = (mem_lvl > 0) & (obuf_lvl + inflight - pop < 2); ram_enb = issue; ram_addrb = rptr; rptr += 1 on issue.
  - mem_lvl counts only words committed on earlier edges, so ram_addra != ram_addrb whenever both ports are enabled. No same-address collision can occur.
- In-flight capture: inflight <= issue. When inflight == 1, ram_dob is written into the skid buffer on the next edge.
- Pop:
  - pop = rd_en & ~empty.
  - The skid buffer is a 2-entry FIFO. dout is always its head entry, driven from a register.
  - A simultaneous pop and capture keeps ordering: the head is removed and the new word enters behind any remaining entry.
- Level rules:
  - mem_lvl += push - issue.
  - count += push - pop.
  - full, afull and empty are recomputed from next-state values and registered.
- Write-to-read latency: a word pushed in cycle N appears on dout with empty = 0 in cycle N+3.
- Throughput: sustained 1 push + 1 pop per cycle once the skid buffer is primed.
- Boundary cases:
  - Push while full: word rejected, ovf pulses, state unchanged. A simultaneous pop does not admit the push in the same cycle.
  - Pop while empty: ignored, unf pulses. A simultaneous push is still accepted.
  - Pointer wrap: 2**ASIZE-1 -> 0 with no status glitch.

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, ram_ena=ram_enb=0 for 10 cycles.
- Single push 0xA5 in cycle 0, no pops -> count=1 in cycle 1, ram_enb=1 with addrb=0 in cycle 1, empty=0 and dout=0xA5 in cycle 3; pop -> empty=1, count=0.
- ASIZE=4: 16 consecutive pushes 0x00..0x0F -> full=1 after the 16th; afull=1 from count=14; 17th push -> ovf pulse, count stays 16; drain -> data 0x00..0x0F in order.
- Continuous push and pop for 100 words with wraparound -> no gaps after priming, output order equals input order, count constant at steady state.
- Pop on empty -> unf pulse, dout/empty/count unchanged. Assert rst while 5 words are held and one read is in flight -> empty=1, count=0 next cycle; the in-flight ram_dob value never appears on dout.
- Random wr_en/rd_en at 50% duty for 10k cycles against a reference queue model -> data and count match every cycle; full/empty never violated.
